// File: rtl/display_pkg.sv
// Shared definitions for the display path: BCD digit width, blank code for the
// downstream 7-segment decoders and the converter FSM state encoding.
package display_pkg;

    localparam int DIGIT_W = 4;

    // Nibble code the decoder/scan stages treat as "segment off".
    localparam logic [DIGIT_W-1:0] BLANK_NIBBLE = 4'hF;

    typedef logic [DIGIT_W-1:0] bcd_digit_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } conv_state_t;

endpackage

// File: rtl/dd_adjust.sv
// Double-dabble correction cell: a digit of 5 or more gets +3 so that the
// following left shift carries correctly into the next decimal digit.
module dd_adjust
    import display_pkg::*;
(
    input  bcd_digit_t din,
    output bcd_digit_t dout
);

    // 4-bit add with the carry deliberately dropped; inputs never exceed 9.
    always_comb begin
        dout = din;
        if (din >= 4'd5) begin
            dout = din + 4'd3;
        end
    end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock)
// feeding the per-digit 7-segment decoders with registered digits and blanking.
module bin2bcd_seq
    import display_pkg::*;
#(
    parameter int BIN_W = 20,
    parameter int NDIG  = 6
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [BIN_W-1:0]  bin,
    output logic              busy,
    output logic              done,
    output logic [4*NDIG-1:0] bcd,
    output logic [NDIG-1:0]   blank,
    output logic              ovf
);

    localparam int ACC_D = NDIG + 1;
    localparam int ACC_W = ACC_D * DIGIT_W;
    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam logic [NDIG-1:0] BLANK_RST = {{(NDIG-1){1'b1}}, 1'b0};

    conv_state_t state, state_nxt;

    logic [CNT_W-1:0]       cnt;
    logic [BIN_W-1:0]       sreg;
    logic [ACC_W-1:0]       acc;
    logic [ACC_W-1:0]       acc_adj;
    logic [ACC_W+BIN_W-1:0] joint;
    logic [ACC_W+BIN_W-1:0] joint_sh;
    logic [ACC_W-1:0]       acc_nxt;
    logic [BIN_W-1:0]       sreg_nxt;
    logic                   last_bit;
    logic                   ovf_nxt;
    logic [NDIG-1:0]        blank_nxt;
    logic                   zero_above;

    // One extra digit beyond NDIG so an out-of-range value is detectable.
    for (genvar d = 0; d < ACC_D; d++) begin : g_adj
        dd_adjust u_adj (
            .din  (acc[d*DIGIT_W +: DIGIT_W]),
            .dout (acc_adj[d*DIGIT_W +: DIGIT_W])
        );
    end

    assign joint    = {acc_adj, sreg};
    assign joint_sh = joint << 1;
    assign acc_nxt  = joint_sh[ACC_W+BIN_W-1 -: ACC_W];
    assign sreg_nxt = joint_sh[BIN_W-1:0];
    assign last_bit = (state == ST_SHIFT) && (cnt == CNT_W'(1));

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start) state_nxt = ST_SHIFT;
            ST_SHIFT: if (cnt == CNT_W'(1)) state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Result flags come from the post-shift value so they land with done.
    always_comb begin
        ovf_nxt    = |acc_nxt[ACC_W-1 -: DIGIT_W];
        blank_nxt  = '0;
        zero_above = 1'b1;
        for (int i = NDIG - 1; i >= 1; i--) begin
            zero_above   = zero_above && (acc_nxt[i*DIGIT_W +: DIGIT_W] == '0);
            blank_nxt[i] = zero_above && !ovf_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
            sreg  <= '0;
            acc   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            bcd   <= '0;
            blank <= BLANK_RST;
            ovf   <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt != ST_IDLE);
            done  <= last_bit;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        sreg <= bin;
                        acc  <= '0;
                        cnt  <= CNT_W'(BIN_W);
                    end
                end
                ST_SHIFT: begin
                    sreg <= sreg_nxt;
                    acc  <= acc_nxt;
                    cnt  <= cnt - 1'b1;
                end
                default: ;
            endcase
            if (last_bit) begin
                bcd   <= acc_nxt[NDIG*DIGIT_W-1:0];
                ovf   <= ovf_nxt;
                blank <= blank_nxt;
            end
        end
    end

endmodule
